// File: rtl/hb_decim_mac_if.sv
// rtl/hb_decim_mac_if.sv - sample-in / decimated-out handshake bundle for hb_decim_mac
interface hb_decim_mac_if;
    logic signed [15:0] data_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] data_out;
    logic               out_valid;

    modport master (
        output data_in,
        output in_valid,
        input  in_ready,
        input  data_out,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/hb_decim_mac.sv
// rtl/hb_decim_mac.sv - 11-tap half-band decimate-by-2 filter with a single time-shared MAC
module hb_decim_mac #(
    parameter logic signed [15:0] C0 = 16'sd285,
    parameter logic signed [15:0] C2 = -16'sd1478,
    parameter logic signed [15:0] C4 = 16'sd9385,
    parameter logic signed [15:0] C5 = 16'sd16384
) (
    input  logic          clk,
    input  logic          reset,
    hb_decim_mac_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic               phase_q, phase_d;
    logic signed [35:0] acc_q, acc_d;
    logic signed [15:0] x_q [0:10];
    logic signed [15:0] x_d [0:10];
    logic signed [15:0] data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic signed [16:0] pre_add;
    logic signed [15:0] coef;
    logic signed [32:0] prod;
    logic signed [35:0] rounded;
    logic signed [35:0] shifted;
    logic signed [15:0] sat_val;

    // Held low during reset so nothing presented in reset is taken.
    assign in_ready      = (state_q == IDLE) && reset;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;

    // Symmetric pair pre-add and coefficient select for the current MAC step.
    always_comb begin
        pre_add = '0;
        coef    = '0;
        case (step_q)
            2'd0: begin
                pre_add = 17'(x_q[0]) + 17'(x_q[10]);
                coef    = C0;
            end
            2'd1: begin
                pre_add = 17'(x_q[2]) + 17'(x_q[8]);
                coef    = C2;
            end
            2'd2: begin
                pre_add = 17'(x_q[4]) + 17'(x_q[6]);
                coef    = C4;
            end
            default: begin
                pre_add = 17'(x_q[5]);
                coef    = C5;
            end
        endcase
        prod = 33'(pre_add) * 33'(coef);
    end

    // Round half up back to Q1.15 and clamp to the 16-bit output range.
    always_comb begin
        rounded = acc_q + 36'sd16384;
        shifted = rounded >>> 15;
        if (shifted > 36'sd32767) begin
            sat_val = 16'sh7FFF;
        end else if (shifted < -36'sd32768) begin
            sat_val = 16'sh8000;
        end else begin
            sat_val = shifted[15:0];
        end
    end

    // Next-state: shift on accept, run four MAC steps after each odd sample, then publish.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        x_d         = x_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d[0] = bus.data_in;
                    for (int k = 1; k < 11; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        state_d = MAC;
                        step_d  = 2'd0;
                        acc_d   = '0;
                    end
                end
            end
            MAC: begin
                acc_d  = acc_q + 36'(prod);
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                data_out_d  = sat_val;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything and aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            phase_q     <= 1'b0;
            acc_q       <= '0;
            x_q         <= '{default: '0};
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: doc/hb_decim_mac.md
HB_DECIM_MAC -- requirements
Module: hb_decim_mac

Interface
REQ-001 Parameter C0, default 285, signed 16-bit Q1.15 coefficient for taps 0 and 10.
REQ-002 Parameter C2, default -1478, signed Q1.15 coefficient for taps 2 and 8.
REQ-003 Parameter C4, default 9385, signed Q1.15 coefficient for taps 4 and 6.
REQ-004 Parameter C5, default 16384, signed Q1.15 centre-tap coefficient; odd taps 1,3,7,9 are zero and SHALL NOT be computed.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-007 data_in  input  16  signed two's-complement input sample.
REQ-008 in_valid  input  1  upstream holds data_in valid.
REQ-009 in_ready  output  1  block can accept a sample this cycle.
REQ-010 data_out  output  16  signed decimated output; drives the downstream 16-bit hold register data input.
REQ-011 out_valid  output  1  one-cycle pulse marking new data_out; drives the downstream register enable.

Function
REQ-012 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; otherwise data_in is ignored and upstream holds it.
REQ-013 On acceptance, the 11-entry x 16-bit delay line SHALL shift: x[0]<=data_in, x[k]<=x[k-1] for k=1..10.
REQ-014 A 1-bit phase flag SHALL toggle on every accepted sample; first sample after reset is even (phase 0).
REQ-015 Even-phase acceptance SHALL only shift; state stays IDLE and in_ready stays 1.
REQ-016 Odd-phase acceptance SHALL move the FSM IDLE -> MAC with step counter cleared and accumulator cleared.
REQ-017 FSM states: IDLE, MAC, OUT; in_ready SHALL equal (state==IDLE) and reset high.
REQ-018 MAC SHALL last exactly 4 cycles, one term per edge: step0 C0*(x[0]+x[10]), step1 C2*(x[2]+x[8]), step2 C4*(x[4]+x[6]), step3 C5*x[5]; then MAC -> OUT.
REQ-019 Pre-adds SHALL be 17-bit signed, products 33-bit signed, accumulator 36-bit signed; no intermediate truncation.
REQ-020 In OUT, result = (acc + 16384) arithmetically shifted right 15 (round half up), saturated to [-32768, 32767]; registered into data_out; out_valid<=1 on the same edge; OUT -> IDLE.
REQ-021 Latency: out_valid SHALL be high in the cycle beginning 5 rising edges after the accepting edge; in_ready low for exactly those 5 cycles.
REQ-022 out_valid SHALL be high exactly one cycle per odd-phase sample; data_out SHALL hold its value until the next OUT update.
REQ-023 in_ready=1 in the out_valid cycle; a sample accepted then is legal and SHALL NOT disturb the presented data_out.
REQ-024 Delay line SHALL NOT shift during MAC or OUT.

Reset
REQ-025 While reset=0 at an edge: delay line, accumulator, step counter, phase <= 0; state <= IDLE; data_out <= 16'h0000; out_valid <= 0.
REQ-026 in_ready SHALL be 0 while reset is 0; input presented during reset is not accepted.
REQ-027 Reset asserted during MAC or OUT SHALL abort the computation; no out_valid SHALL follow for that pair.

Verification
REQ-028 Impulse: zero then 1000 then zeros (in_valid=1 continuously) -> out_valid sequence data_out = 9, -45, 286, 286, -45, 9, 0.
REQ-029 DC: continuous 32767 -> settled data_out 32767; continuous -32768 -> settled -32768; no saturation.
REQ-030 Saturation: x[0],x[4],x[5],x[6],x[10]=32767, x[2],x[8]=-32768 -> data_out 16'h7FFF; sign-inverted pattern -> 16'h8000.
REQ-031 Handshake timing: odd sample accepted at edge E -> in_ready low edges E+1..E+5, out_valid high one cycle after E+5; in_valid held high while busy -> no extra sample consumed.
REQ-032 Reset at MAC step 2 -> next cycle data_out=0, out_valid=0, in_ready=0; after release first sample is even phase, no output until the second sample.
REQ-033 Stalled upstream: in_valid toggling randomly -> outputs identical to continuous-feed golden model, one out_valid per two accepted samples.
